// File: rtl/rv32_pkg.sv
// Shared types and bus widths for the rv32 memory responder slice.
package rv32_pkg;

  localparam int BUS_BE_W   = 4;
  localparam int BUS_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } resp_state_t;

  // Half-open window test done in 33 bits so a window ending at 4 GiB cannot wrap.
  function automatic logic addr_in_window(input logic [31:0] addr,
                                          input logic [32:0] lo,
                                          input logic [32:0] hi);
    return ({1'b0, addr} >= lo) && ({1'b0, addr} < hi);
  endfunction

endpackage

// File: rtl/rv32_mod_sram_be.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module rv32_mod_sram_be
  import rv32_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic [BUS_BE_W-1:0]   be_i,
  input  logic [IDX_W-1:0]      idx_i,
  input  logic [BUS_DATA_W-1:0] wdata_i,
  output logic [BUS_DATA_W-1:0] rdata_o
);

  logic [BUS_DATA_W-1:0] mem_q [DEPTH_WORDS];
  logic [BUS_DATA_W-1:0] rdata_q;

  // Storage array is deliberately left without reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < BUS_BE_W; i++) begin
        if (be_i[i]) begin
          mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  // Read word captured in the same cycle as a write would be committed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= {BUS_DATA_W{1'b0}};
    end else if (re_i) begin
      rdata_q <= mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/rv32_mod_mem_responder.sv
// Responder end of the req/ack/err memory handshake: latches a request, waits
// WAIT_STATES cycles, checks range/alignment/byte enables, then pulses ack or err.
module rv32_mod_mem_responder
  import rv32_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  wr,
  input  logic [BUS_BE_W-1:0]   be,
  input  logic [31:0]           addr,
  input  logic [BUS_DATA_W-1:0] wdata,
  output logic                  ack,
  output logic                  err,
  output logic [BUS_DATA_W-1:0] rdata
);

  localparam int          IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [32:0] WIN_LO    = {1'b0, BASE_ADDR};
  localparam logic [32:0] WIN_HI    = WIN_LO + (33'(DEPTH_WORDS) * 33'd4);
  localparam logic        NO_WAIT   = (WAIT_STATES == 0);
  localparam logic [3:0]  WAIT_INIT = NO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

  resp_state_t           state_q;
  logic [3:0]            cnt_q;
  logic [31:0]           addr_q;
  logic                  wr_q;
  logic [BUS_BE_W-1:0]   be_q;
  logic [BUS_DATA_W-1:0] wdata_q;
  logic                  err_pend_q;
  logic                  ack_q;
  logic                  err_q;

  logic [31:0]           eff_addr_s;
  logic                  eff_wr_s;
  logic [BUS_BE_W-1:0]   eff_be_s;
  logic [BUS_DATA_W-1:0] eff_wdata_s;
  logic                  commit_s;
  logic                  reject_s;
  logic [IDX_W-1:0]      idx_s;
  logic                  ram_we_s;
  logic                  ram_re_s;
  logic [BUS_DATA_W-1:0] ram_rdata_s;

  // With no wait states the access commits on the accepting edge, so the live
  // bus is used in IDLE and the latched copy everywhere else.
  always_comb begin
    eff_addr_s  = addr_q;
    eff_wr_s    = wr_q;
    eff_be_s    = be_q;
    eff_wdata_s = wdata_q;
    if (state_q == IDLE) begin
      eff_addr_s  = addr;
      eff_wr_s    = wr;
      eff_be_s    = be;
      eff_wdata_s = wdata;
    end else begin
      eff_addr_s  = addr_q;
      eff_wr_s    = wr_q;
      eff_be_s    = be_q;
      eff_wdata_s = wdata_q;
    end
  end

  // Commit edge detection, request screening and RAM strobes.
  always_comb begin
    commit_s = ((state_q == IDLE) && req && NO_WAIT) ||
               ((state_q == WAIT) && (cnt_q == 4'd0));
    reject_s = !addr_in_window(eff_addr_s, WIN_LO, WIN_HI) ||
               (eff_addr_s[1:0] != 2'b00) ||
               (eff_wr_s && (eff_be_s == 4'b0000));
    idx_s    = IDX_W'((eff_addr_s - BASE_ADDR) >> 2);
    ram_we_s = commit_s && eff_wr_s && !reject_s;
    ram_re_s = commit_s && !eff_wr_s && !reject_s;
  end

  // Handshake FSM: request latch, wait counter and response pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= 32'h0000_0000;
      wr_q       <= 1'b0;
      be_q       <= 4'b0000;
      wdata_q    <= {BUS_DATA_W{1'b0}};
      err_pend_q <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            addr_q  <= addr;
            wr_q    <= wr;
            be_q    <= be;
            wdata_q <= wdata;
            cnt_q   <= WAIT_INIT;
            if (NO_WAIT) begin
              state_q    <= RESP;
              err_pend_q <= reject_s;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q    <= RESP;
            err_pend_q <= reject_s;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          ack_q   <= !err_pend_q;
          err_q   <= err_pend_q;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  rv32_mod_sram_be #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_sram (
    .clk_i   (clk),
    .rst_ni  (reset),
    .we_i    (ram_we_s),
    .re_i    (ram_re_s),
    .be_i    (eff_be_s),
    .idx_i   (idx_s),
    .wdata_i (eff_wdata_s),
    .rdata_o (ram_rdata_s)
  );

  assign ack   = ack_q;
  assign err   = err_q;
  // wr_q still describes the finished access during the ack cycle.
  assign rdata = (ack_q && !wr_q) ? ram_rdata_s : {BUS_DATA_W{1'b0}};

endmodule

// File: tb/tb_rv32_mod_mem_responder.sv
// Scoreboard bench: one responder with no wait states, one with three.
module tb_rv32_mod_mem_responder;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] TOP   = BASE + 32'(4 * DEPTH);

  logic        clk = 1'b0;
  logic        reset, req0, req3, wr;
  logic [3:0]  be;
  logic [31:0] addr, wdata;
  logic        ack0, err0, ack3, err3;
  logic [31:0] rdata0, rdata3;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mdl [2][DEPTH];

  always #5 clk = ~clk;

  rv32_mod_mem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .wr(wr), .be(be), .addr(addr), .wdata(wdata),
    .ack(ack0), .err(err0), .rdata(rdata0));

  rv32_mod_mem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(3)) dut3 (
    .clk(clk), .reset(reset), .req(req3), .wr(wr), .be(be), .addr(addr), .wdata(wdata),
    .ack(ack3), .err(err3), .rdata(rdata3));

  // Reference model: decide err/rdata and update the shadow memory.
  function automatic void push_exp(input int sel, input logic w, input logic [3:0] b,
                                   input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int   idx;
    e.err   = (a < BASE) || (a >= TOP) || (a[1:0] != 2'b00) || (w && (b == 4'b0000));
    e.rdata = 32'h0;
    if (!e.err) begin
      idx = int'((a - BASE) >> 2);
      if (w) begin
        for (int i = 0; i < 4; i++) if (b[i]) mdl[sel][idx][8*i +: 8] = d[8*i +: 8];
      end else begin
        e.rdata = mdl[sel][idx];
      end
    end
    exp_q.push_back(e);
  endfunction

  task automatic access(input int sel, input logic w, input logic [3:0] b,
                        input logic [31:0] a, input logic [31:0] d, input string name);
    int          ws, n;
    bit          seen;
    exp_t        e;
    logic        a_o, e_o;
    logic [31:0] r_o;
    ws = (sel == 1) ? 3 : 0;
    push_exp(sel, w, b, a, d);
    wr = w; be = b; addr = a; wdata = d;
    if (sel == 1) req3 = 1'b1; else req0 = 1'b1;
    n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      a_o = (sel == 1) ? ack3 : ack0;
      e_o = (sel == 1) ? err3 : err0;
      r_o = (sel == 1) ? rdata3 : rdata0;
      if (a_o || e_o) begin
        seen = 1'b1;
        req0 = 1'b0; req3 = 1'b0;
        e = exp_q.pop_front();
        chk_cnt++;
        if (n !== ws + 2) $display("FAIL %s latency: got %0d cycles, want %0d", name, n, ws + 2);
        else pass_cnt++;
        chk_cnt++;
        if (e_o !== e.err) $display("FAIL %s err: got %b, want %b", name, e_o, e.err);
        else pass_cnt++;
        chk_cnt++;
        if (a_o !== !e.err) $display("FAIL %s ack: got %b, want %b", name, a_o, !e.err);
        else pass_cnt++;
        chk_cnt++;
        if (r_o !== e.rdata) $display("FAIL %s rdata: got %h, want %h", name, r_o, e.rdata);
        else pass_cnt++;
      end
    end
    if (!seen) begin
      req0 = 1'b0; req3 = 1'b0;
      e = exp_q.pop_front();
      chk_cnt++;
      $display("FAIL %s timeout: got no response in %0d cycles, want one after %0d", name, n, ws + 2);
    end
    @(negedge clk);
    a_o = (sel == 1) ? ack3 : ack0;
    e_o = (sel == 1) ? err3 : err0;
    r_o = (sel == 1) ? rdata3 : rdata0;
    chk_cnt++;
    if ({a_o, e_o, r_o} !== 34'h0)
      $display("FAIL %s after-pulse: got ack=%b err=%b rdata=%h, want all 0", name, a_o, e_o, r_o);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b0; req0 = 1'b0; req3 = 1'b0;
    wr = 1'b0; be = 4'h0; addr = 32'h0; wdata = 32'h0;
    repeat (2) @(negedge clk);
    chk_cnt++;
    if ({ack0, err0, rdata0} !== 34'h0) $display("FAIL reset dut0: got ack=%b err=%b rdata=%h, want 0", ack0, err0, rdata0);
    else pass_cnt++;
    chk_cnt++;
    if ({ack3, err3, rdata3} !== 34'h0) $display("FAIL reset dut3: got ack=%b err=%b rdata=%h, want 0", ack3, err3, rdata3);
    else pass_cnt++;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    access(0, 1'b1, 4'hF, BASE + 32'd4, 32'hDEADBEEF, "wr_full");
    access(0, 1'b0, 4'hF, BASE + 32'd4, 32'h0, "rd_full");
  endtask

  task automatic test_byte_enable();
    access(0, 1'b1, 4'b0001, BASE + 32'd4, 32'h000000AA, "wr_be1");
    access(0, 1'b0, 4'hF, BASE + 32'd4, 32'h0, "rd_be1");
    access(0, 1'b1, 4'hF, BASE + 32'd12, 32'hFFFFFFFF, "wr_ones");
    access(0, 1'b1, 4'b0110, BASE + 32'd12, 32'h12345678, "wr_be6");
    access(0, 1'b0, 4'hF, BASE + 32'd12, 32'h0, "rd_be6");
  endtask

  task automatic test_errors();
    access(0, 1'b0, 4'hF, TOP, 32'h0, "err_top");
    access(0, 1'b0, 4'hF, BASE - 32'd4, 32'h0, "err_below");
    access(0, 1'b1, 4'hF, BASE + 32'd2, 32'h12345678, "err_align");
    access(0, 1'b1, 4'h0, BASE + 32'd4, 32'h0, "err_be0");
    access(0, 1'b0, 4'h0, BASE + 32'd4, 32'h0, "rd_unchanged");
    access(0, 1'b1, 4'hF, TOP - 32'd4, 32'h0BAD_F00D, "wr_last");
    access(0, 1'b0, 4'hF, TOP - 32'd4, 32'h0, "rd_last");
  endtask

  task automatic test_wait_states();
    access(1, 1'b1, 4'hF, BASE + 32'd16, 32'hA5A55A5A, "ws3_wr");
    access(1, 1'b0, 4'hF, BASE + 32'd16, 32'h0, "ws3_rd");
    access(1, 1'b0, 4'hF, BASE + 32'd1, 32'h0, "ws3_err");
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic exp_ack;
    for (int k = 0; k < 3; k++) push_exp(0, 1'b0, 4'hF, BASE + 32'd4, 32'h0);
    wr = 1'b0; be = 4'hF; addr = BASE + 32'd4; req0 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      exp_ack = (k == 2) || (k == 4) || (k == 6);
      chk_cnt++;
      if (ack0 !== exp_ack || err0 !== 1'b0)
        $display("FAIL b2b cycle %0d: got ack=%b err=%b, want ack=%b err=0", k, ack0, err0, exp_ack);
      else pass_cnt++;
      if (ack0 === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk_cnt++;
        if (rdata0 !== e.rdata) $display("FAIL b2b rdata cycle %0d: got %h, want %h", k, rdata0, e.rdata);
        else pass_cnt++;
      end
      if (k == 6) req0 = 1'b0;
    end
  endtask

  task automatic test_reset_mid_access();
    bit quiet;
    access(1, 1'b1, 4'hF, BASE + 32'd8, 32'h11223344, "pre_wr");
    wr = 1'b1; be = 4'hF; addr = BASE + 32'd8; wdata = 32'hCAFEF00D; req3 = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0; req3 = 1'b0;
    #1;
    chk_cnt++;
    if ({ack3, err3, rdata3} !== 34'h0) $display("FAIL mid_reset outputs: got ack=%b err=%b rdata=%h, want 0", ack3, err3, rdata3);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b1;
    quiet = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (ack3 !== 1'b0 || err3 !== 1'b0) quiet = 1'b0;
    end
    chk_cnt++;
    if (!quiet) $display("FAIL mid_reset aborted: got a response pulse, want none");
    else pass_cnt++;
    access(1, 1'b0, 4'hF, BASE + 32'd8, 32'h0, "post_rd");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by time limit, want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_read();
    test_byte_enable();
    test_errors();
    test_wait_states();
    test_back_to_back();
    test_reset_mid_access();
    chk_cnt++;
    if (exp_q.size() != 0) $display("FAIL scoreboard drain: got %0d left, want 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
